// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs, with a synchronous clear used on redirect.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  input  logic                      clear,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, memory request/response, instruction buffer, redirect.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_q, out_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;
  logic [CW:0]           occupancy;
  logic                  credit, req_fire, rsp_keep;
  logic [ADDR_WIDTH-1:0] rsp_pc;

  assign occupancy = {1'b0, out_q} + {1'b0, fifo_count};
  assign credit    = occupancy < (CW + 1)'(FIFO_DEPTH);

  assign req_valid = !rst && (state_q == FETCH) && credit && !redirect;
  assign req_addr  = pc_q;
  assign req_fire  = req_valid && req_ready;

  // In FETCH the outstanding requests are consecutive words ending at pc_q-4,
  // so the oldest one (the one answering now) sits out_q words behind pc_q.
  assign rsp_pc     = pc_q - ADDR_WIDTH'({out_q, 2'b00});
  assign rsp_keep   = rsp_valid && (state_q == FETCH) && !redirect;
  assign fifo_push  = rsp_keep;
  assign fifo_wdata = {rsp_pc, rsp_data};

  assign instr_valid = !rst && !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign instr_pc    = instr_valid ? fifo_rdata[FW-1:DATA_WIDTH] : '0;

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .clear (redirect),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + CW'(req_fire) - CW'(rsp_valid);
    if (redirect) begin
      pc_d    = redirect_pc & ~ADDR_WIDTH'(3);
      state_d = (out_d != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      if ((state_q == DRAIN) && (out_d == '0)) state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && (out_q == '0)));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] dropped_q, dropped_d;
  logic [CW-1:0] flushed;

  // Dropped = responses discarded (DRAIN or redirect cycle) plus entries flushed by redirect.
  always_comb begin
    fetched_d = fetched_q + 32'(fifo_pop);
    flushed   = redirect ? (fifo_count - CW'(fifo_pop)) : '0;
    dropped_d = dropped_q + 32'(flushed) + 32'(rsp_valid && !rsp_keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a stream-level reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // Memory model and reference state.
  mreq_t       mq[$];
  int          cyc = 0;
  int          buffered = 0;   // words the decode side should see buffered
  int          stale = 0;      // in-flight responses that belong to a flushed stream
  logic [31:0] exp_req = 0;    // next address the unit should request
  logic [31:0] exp_ipc = 0;    // pc of the next instruction decode should receive
  logic [31:0] data_xor = 0;
  logic [31:0] n_pops = 0, n_drops = 0;
  bit          hold = 0;
  logic [31:0] held_instr, held_pc;

  int rdy_pct = 100, ird_pct = 100, max_lat = 1, redir_pm = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit force_redir, input logic [31:0] tgt);
    bit pop;
    @(negedge clk);
    rsp_valid   = (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_data    = rsp_valid ? (mq[0].addr ^ data_xor) : $urandom;
    req_ready   = ($urandom_range(99) < rdy_pct);
    instr_ready = ($urandom_range(99) < ird_pct);
    redirect    = force_redir || ($urandom_range(999) < redir_pm);
    redirect_pc = force_redir ? tgt : $urandom;
    #1;
    chk("req_valid", req_valid,
        !redirect && (stale == 0) && (mq.size() + buffered < DEPTH));
    chk("instr_valid", instr_valid, buffered > 0);
    if (hold) begin
      chk("hold_instr", instr, held_instr);
      chk("hold_pc", instr_pc, held_pc);
    end
    if (req_valid && req_ready) chk("req_addr", req_addr, exp_req);
    pop = instr_valid && instr_ready;
    if (pop) begin
      chk("instr_pc", instr_pc, exp_ipc);
      chk("instr", instr, exp_ipc ^ data_xor);
      n_pops++;
      buffered--;
      exp_ipc += 4;
    end
    hold = instr_valid && !instr_ready && !redirect;
    held_instr = instr;
    held_pc = instr_pc;
    if (rsp_valid) begin
      void'(mq.pop_front());
      if (redirect || stale > 0) begin
        n_drops++;
        if (stale > 0) stale--;
      end else begin
        buffered++;
      end
    end
    if (req_valid && req_ready) begin
      mq.push_back('{addr: req_addr, due: cyc + $urandom_range(max_lat, 1)});
      exp_req += 4;
    end
    if (redirect) begin
      n_drops += buffered;
      buffered = 0;
      stale = mq.size();
      exp_req = redirect_pc & ~32'h3;
      exp_ipc = redirect_pc & ~32'h3;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_req_valid", req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 0);
      chk("rst_perf_dropped", perf_dropped, 0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    buffered = 0;
    stale = 0;
    exp_req = 0;
    exp_ipc = 0;
    hold = 0;
    n_pops = 0;
    n_drops = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_ready = 0; rsp_valid = 0; rsp_data = 0;
    instr_ready = 0; redirect = 0; redirect_pc = 0;
    do_reset();

    // Streaming with a 1-cycle memory that returns the address as data.
    rdy_pct = 100; ird_pct = 100; max_lat = 1; redir_pm = 0; data_xor = 0;
    repeat (30) step(0, 0);

    // Decode stall, then resume.
    ird_pct = 0;
    repeat (6) step(0, 0);
    ird_pct = 100;
    repeat (10) step(0, 0);

    // Redirect with exactly one request in flight.
    max_lat = 3;
    n = 0;
    while (!(mq.size() == 1 && mq[0].due > cyc && stale == 0) && n < 50) begin
      step(0, 0);
      n++;
    end
    chk("wait_one_outstanding", n < 50, 1);
    step(1, 32'h100);
    repeat (15) step(0, 0);

    // Redirect coincident with a response and a pop.
    max_lat = 1;
    n = 0;
    while (!(mq.size() > 0 && mq[0].due <= cyc && buffered > 0 && stale == 0) && n < 50) begin
      step(0, 0);
      n++;
    end
    chk("wait_rsp_and_pop", n < 50, 1);
    step(1, 32'h300);
    repeat (10) step(0, 0);

    // Misaligned target and PC wrap-around.
    step(1, 32'h203);
    repeat (8) step(0, 0);
    step(1, 32'hFFFF_FFF4);
    repeat (12) step(0, 0);

    // Random traffic: backpressure, variable latency, random redirects.
    do_reset();
    data_xor = 32'h5A5A_C3C3;
    rdy_pct = 70; ird_pct = 70; max_lat = 4; redir_pm = 40;
    repeat (3000) step(0, 0);

    @(negedge clk);
    rsp_valid = 0; req_ready = 0; instr_ready = 0; redirect = 0;
`ifdef FETCH_PERF_CNT_EN
    #1;
    chk("perf_fetched", perf_fetched, n_pops);
    chk("perf_dropped", perf_dropped, n_drops);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
